spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 34 +++
 rtl/spi_slave_if.sv | 12 +
 rtl/byte_fifo.sv | 54 +++++
 rtl/spi_slave.sv | 179 +++++++++++++++++
 tb/tb_spi_slave.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI target block: register map, STATUS/CTRL
// bit positions, defaults and state encodings.
package spi_slave_pkg;

  localparam int         DEF_FIFO_DEPTH = 8;
  localparam logic [7:0] DEF_IDLE_BYTE  = 8'hFF;
  localparam int         CNT_W          = 5;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_t;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_RX_OVF      = 2;
  localparam int ST_TX_UND      = 3;
  localparam int ST_CSB_ACT     = 4;
  localparam int ST_RX_CNT      = 8;
  localparam int ST_TX_CNT      = 16;

  localparam int CTRL_IRQ_EN_RX  = 0;
  localparam int CTRL_IRQ_EN_ERR = 1;
  localparam int CTRL_TX_FLUSH   = 2;
  localparam int CTRL_RX_FLUSH   = 3;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// CPU-side register bus of the SPI target: single-cycle ready pulse handshake.
interface spi_slave_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module byte_fifo
  import spi_slave_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = CNT_W'(cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target with RX/TX byte FIFOs, exposed to the CPU through a
// DATA/STATUS/CTRL register bus and a level interrupt.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [7:0] IDLE_BYTE  = DEF_IDLE_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus,
  input  logic        spi_csb,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  logic [1:0] csb_sync, sck_sync, mosi_sync;
  logic       csb_d, sck_d;
  logic       csb_fall, csb_rise, sck_rise, sck_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_sync  <= 2'b11;
      sck_sync  <= '0;
      mosi_sync <= '0;
      csb_d     <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[0], spi_csb};
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      csb_d     <= csb_sync[1];
      sck_d     <= sck_sync[1];
    end
  end

  assign csb_fall = csb_d & ~csb_sync[1];
  assign csb_rise = ~csb_d & csb_sync[1];
  assign sck_rise = ~sck_d & sck_sync[1];
  assign sck_fall = sck_d & ~sck_sync[1];

  // Bus decode
  reg_sel_t             sel;
  logic                 acc, rd, wr_lo;
  logic                 bus_rx_pop, bus_tx_push, ctrl_wr, st_wr, tx_flush, rx_flush;
  logic                 rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]           rx_dout, tx_dout;
  logic [CNT_W-1:0]     rx_count, tx_count;
  logic                 en_rx, en_err, rx_ovf, tx_und;
  logic [31:0]          rd_val, status;
  logic                 unused_bus;

  assign sel         = reg_sel_t'(bus.addr[3:2]);
  assign acc         = bus.valid & ~bus.ready;
  assign rd          = acc & (bus.wstrb == '0);
  assign wr_lo       = acc & bus.wstrb[0];
  assign bus_rx_pop  = rd & (sel == REG_DATA);
  assign bus_tx_push = wr_lo & (sel == REG_DATA);
  assign ctrl_wr     = wr_lo & (sel == REG_CTRL);
  assign st_wr       = wr_lo & (sel == REG_STATUS);
  assign tx_flush    = ctrl_wr & bus.wdata[CTRL_TX_FLUSH];
  assign rx_flush    = ctrl_wr & bus.wdata[CTRL_RX_FLUSH];
  assign unused_bus  = &{1'b0, bus.addr[31:4], bus.addr[1:0], bus.wdata[31:8]};

  // SPI shift engine
  spi_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] tx_shift, tx_shift_n, rx_shift, rx_shift_n;
  logic       rx_push, tx_load, tx_pop, set_ovf, set_und;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SPI_IDLE;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    tx_load    = 1'b0;
    unique case (state)
      SPI_IDLE: begin
        if (csb_fall) begin
          state_n   = SPI_ACTIVE;
          bit_cnt_n = '0;
          tx_load   = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if (csb_rise) begin
          state_n   = SPI_IDLE;
          bit_cnt_n = '0;
        end else if (sck_rise) begin
          rx_shift_n = {rx_shift[6:0], mosi_sync[1]};
          bit_cnt_n  = bit_cnt + 3'd1;
          rx_push    = (bit_cnt == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt == '0) tx_load = 1'b1;
          else               tx_shift_n = {tx_shift[6:0], 1'b0};
        end
      end
      default: state_n = SPI_IDLE;
    endcase
    if (tx_load) tx_shift_n = tx_empty ? IDLE_BYTE : tx_dout;
  end

  assign tx_pop  = tx_load & ~tx_empty;
  assign set_und = tx_load & tx_empty;
  // A full RX still takes the byte when the bus pops in the same cycle
  assign set_ovf = rx_push & rx_full & ~bus_rx_pop;

  assign spi_miso    = (state == SPI_ACTIVE) & tx_shift[7];
  assign spi_miso_oe = (state == SPI_ACTIVE);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(bus_rx_pop), .flush(rx_flush),
    .din(rx_shift_n), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(bus_tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(bus.wdata[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_comb begin
    status                         = '0;
    status[ST_RX_NONEMPTY]         = ~rx_empty;
    status[ST_TX_FULL]             = tx_full;
    status[ST_RX_OVF]              = rx_ovf;
    status[ST_TX_UND]              = tx_und;
    status[ST_CSB_ACT]             = (state == SPI_ACTIVE);
    status[ST_RX_CNT +: CNT_W]     = rx_count;
    status[ST_TX_CNT +: CNT_W]     = tx_count;
    rd_val = '0;
    unique case (sel)
      REG_DATA:   rd_val = rx_empty ? 32'd0 : {24'd0, rx_dout};
      REG_STATUS: rd_val = status;
      REG_CTRL:   rd_val = {30'd0, en_err, en_rx};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      en_rx     <= 1'b0;
      en_err    <= 1'b0;
      rx_ovf    <= 1'b0;
      tx_und    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      bus.ready <= acc;
      bus.rdata <= rd ? rd_val : '0;
      if (ctrl_wr) begin
        en_rx  <= bus.wdata[CTRL_IRQ_EN_RX];
        en_err <= bus.wdata[CTRL_IRQ_EN_ERR];
      end
      rx_ovf <= (rx_ovf & ~(st_wr & bus.wdata[ST_RX_OVF])) | set_ovf;
      tx_und <= (tx_und & ~(st_wr & bus.wdata[ST_TX_UND])) | set_und;
      irq    <= (en_rx & ~rx_empty) | (en_err & (rx_ovf | tx_und));
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed + randomized bench for spi_slave: a mode-0 host model drives the
// SPI pins, a queue-based reference model predicts bus reads and MISO bytes.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_CTRL = 32'h8, A_RSVD = 32'hC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_csb = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, irq;

  spi_slave_if bus();

  spi_slave #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_ovf, m_und, m_active;
  logic [7:0] m_next_miso;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (rxq.size() != 0);
    s[1]     = (txq.size() == DEPTH);
    s[2]     = m_ovf;
    s[3]     = m_und;
    s[4]     = m_active;
    s[12:8]  = 5'(rxq.size());
    s[20:16] = 5'(txq.size());
    return s;
  endfunction

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] r);
    int lat;
    lat = 8;
    r   = '0;
    clks(1);
    bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    for (int i = 0; i < 8; i++) begin
      clks(1);
      if (bus.ready) begin
        lat = i;
        r   = bus.rdata;
        break;
      end
    end
    bus.valid = 1'b0; bus.wstrb = '0;
    chk("bus_latency", 32'(lat), 32'd0);
    if (lat < 8) begin
      clks(1);
      chk("ready_single_pulse", 32'(bus.ready), 32'd0);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(a, d, 4'h1, dummy);
    if (a == A_DATA && txq.size() < DEPTH) txq.push_back(d[7:0]);
    if (a == A_STATUS) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_und = 0;
    end
    if (a == A_CTRL) begin
      if (d[2]) txq.delete();
      if (d[3]) rxq.delete();
    end
  endtask

  task automatic read_data(input string tag);
    logic [31:0] r, e;
    e = (rxq.size() != 0) ? {24'd0, rxq.pop_front()} : 32'd0;
    bus_xfer(A_DATA, 32'd0, 4'h0, r);
    chk(tag, r, e);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] r;
    bus_xfer(A_STATUS, 32'd0, 4'h0, r);
    chk(tag, r, exp_status());
  endtask

  task automatic m_load();
    if (txq.size() != 0) m_next_miso = txq.pop_front();
    else begin
      m_next_miso = 8'hFF;
      m_und = 1;
    end
  endtask

  task automatic host_csb_low();
    spi_csb = 1'b0;
    clks(8);
    m_active = 1;
    m_load();
  endtask

  task automatic host_csb_high();
    clks(4);
    spi_csb = 1'b1;
    clks(8);
    m_active = 0;
  endtask

  task automatic host_bits(input logic [7:0] b, input int n, output logic [7:0] miso_b);
    miso_b = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      clks(4);
      miso_b = {miso_b[6:0], spi_miso};
      spi_sck = 1'b1;
      clks(8);
      spi_sck = 1'b0;
      clks(4);
    end
  endtask

  task automatic host_byte(input logic [7:0] b, input string tag);
    logic [7:0] got;
    host_bits(b, 8, got);
    chk(tag, {24'd0, got}, {24'd0, m_next_miso});
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else m_ovf = 1;
    m_load();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  dummy8;
    bus.valid = 1'b0; bus.wstrb = '0; bus.addr = '0; bus.wdata = '0;
    clks(3);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    clks(2);
    check_status("rst_status");
    bus_xfer(A_CTRL, 32'd0, 4'h0, r);
    chk("rst_ctrl", r, 32'd0);

    // Two-byte full-duplex exchange
    bus_write(A_DATA, 32'hA5);
    bus_write(A_DATA, 32'h3C);
    check_status("tx_loaded_status");
    host_csb_low();
    chk("miso_oe_active", 32'(spi_miso_oe), 32'd1);
    check_status("active_status");
    host_byte(8'h11, "miso_byte0");
    host_byte(8'h22, "miso_byte1");
    host_csb_high();
    chk("miso_oe_idle", 32'(spi_miso_oe), 32'd0);
    read_data("rx_byte0");
    read_data("rx_byte1");
    check_status("after_xfer_status");

    // Underrun with empty TX, then clear it
    bus_write(A_STATUS, 32'hC);
    host_csb_low();
    host_byte(8'($urandom), "miso_idle_byte");
    host_csb_high();
    check_status("underrun_status");
    bus_write(A_STATUS, 32'h8);
    check_status("underrun_cleared");
    read_data("underrun_rx");

    // Overflow: nine bytes without reads
    bus_write(A_STATUS, 32'hC);
    host_csb_low();
    for (int i = 1; i <= 9; i++) host_byte(8'(i), $sformatf("ovf_miso%0d", i));
    host_csb_high();
    check_status("overflow_status");
    for (int i = 0; i < 9; i++) read_data($sformatf("ovf_read%0d", i));
    bus_xfer(A_RSVD, 32'd0, 4'h0, r);
    chk("rsvd_read", r, 32'd0);

    // Aborted partial byte, then an intact one
    host_csb_low();
    host_bits(8'hF0, 5, dummy8);
    host_csb_high();
    check_status("abort_status");
    host_csb_low();
    host_byte(8'h5A, "after_abort_miso");
    host_csb_high();
    read_data("after_abort_rx");

    // Randomized mix of bus traffic and host bytes
    for (int it = 0; it < 6; it++) begin
      int nw, nh, nr;
      nw = $urandom_range(0, 4);
      nh = $urandom_range(1, 3);
      nr = $urandom_range(0, 4);
      if (it == 3) bus_write(A_CTRL, 32'hC);
      for (int k = 0; k < nw; k++) bus_write(A_DATA, 32'($urandom));
      host_csb_low();
      for (int k = 0; k < nh; k++) host_byte(8'($urandom), $sformatf("rand_miso_%0d_%0d", it, k));
      host_csb_high();
      for (int k = 0; k < nr; k++) read_data($sformatf("rand_rx_%0d_%0d", it, k));
      check_status($sformatf("rand_status_%0d", it));
    end

    // Interrupt behaviour
    bus_write(A_CTRL, 32'hC);
    bus_write(A_STATUS, 32'hC);
    bus_write(A_CTRL, 32'h1);
    bus_xfer(A_CTRL, 32'd0, 4'h0, r);
    chk("ctrl_readback", r, 32'h1);
    clks(2);
    chk("irq_idle", 32'(irq), 32'd0);
    host_csb_low();
    host_byte(8'h77, "irq_miso");
    chk("irq_rx_high", 32'(irq), 32'd1);
    host_csb_high();
    read_data("irq_rx_data");
    clks(2);
    chk("irq_rx_low", 32'(irq), 32'd0);
    bus_write(A_CTRL, 32'h2);
    clks(2);
    chk("irq_err", 32'(irq), 32'(m_und | m_ovf));
    bus_write(A_STATUS, 32'hC);
    clks(2);
    chk("irq_err_cleared", 32'(irq), 32'd0);

    // Reset in the middle of a byte with TX still holding two entries
    bus_write(A_CTRL, 32'hC);
    bus_write(A_DATA, 32'h12);
    bus_write(A_DATA, 32'h34);
    bus_write(A_DATA, 32'h56);
    host_csb_low();
    host_bits(8'hAA, 3, dummy8);
    reset = 1'b1;
    spi_csb = 1'b1;
    spi_sck = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.ready), 32'd0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_miso", 32'(spi_miso), 32'd0);
    chk("midrst_miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    clks(3);
    reset = 1'b0;
    rxq.delete(); txq.delete();
    m_ovf = 0; m_und = 0; m_active = 0;
    clks(4);
    check_status("midrst_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
